// File: rtl/csk_sub_pkg.sv
// Shared types and helpers for the sequential borrow-skip subtractor.
package csk_sub_pkg;

  localparam int SLICE_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  function automatic int nslices(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/sub2b_wsk.sv
// Combinational 2-bit borrow-skip subtractor slice: two full-subtractor bits
// plus a skip mux that forwards bin when both bits propagate.
module sub2b_wsk (
  input  logic [1:0] inA,
  input  logic [1:0] inB,
  input  logic       bin,
  output logic [1:0] diff,
  output logic       bout
);

  logic [1:0] p;
  logic       br1;
  logic       br2;

  always_comb begin
    p       = ~(inA ^ inB);
    diff[0] = inA[0] ^ inB[0] ^ bin;
    br1     = (~inA[0] & inB[0]) | (p[0] & bin);
    diff[1] = inA[1] ^ inB[1] ^ br1;
    br2     = (~inA[1] & inB[1]) | (p[1] & br1);
    // Skip path is logically equal to the ripple path; it only shortens timing.
    bout    = (p[0] & p[1]) ? bin : br2;
  end

endmodule

// File: rtl/csk_sub_seq.sv
// Multi-cycle subtractor diff = a - b - bin, two bits per cycle LSB first.
// Optional macro CSK_SUB_OVF_EN adds the signed-overflow output ovf.
module csk_sub_seq
  import csk_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CSK_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSL   = nslices(WIDTH);
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [IDX_W:0]   bitpos;
  logic [1:0]       sl_a;
  logic [1:0]       sl_b;
  logic [1:0]       sl_diff;
  logic             sl_bout;

  always_comb begin
    bitpos = {idx_q, 1'b0};
    sl_a   = a_q[bitpos +: SLICE_W];
    sl_b   = b_q[bitpos +: SLICE_W];
  end

  sub2b_wsk u_slice (
    .inA  (sl_a),
    .inB  (sl_b),
    .bin  (br_q),
    .diff (sl_diff),
    .bout (sl_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    idx_d   = idx_q;
    res_d   = res_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[bitpos +: SLICE_W] = sl_diff;
        br_d  = sl_bout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          bout_d  = sl_bout;
          // Borrow into the MSB is recovered from the MSB difference bit.
          ovf_d   = sl_bout ^ (sl_diff[1] ^ sl_a[1] ^ sl_b[1]);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = res_q;
  assign bout = bout_q;

`ifdef CSK_SUB_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csk_sub_seq.sv
// Randomized self-checking bench for csk_sub_seq against a cycle-count model.
module tb_csk_sub_seq;

  localparam int W   = 8;
  localparam int NSL = W / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef CSK_SUB_OVF_EN
  logic         ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  csk_sub_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef CSK_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles remaining in the current operation (0 = idle),
  // the result of the operation in flight and the result on display.
  int           cnt;
  logic [W-1:0] new_d, held_d;
  logic         new_b, held_b;
  logic         new_o, held_o;
  logic [W:0]   tmp;
  int           sres;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 0;
      new_d  <= '0;
      new_b  <= 1'b0;
      new_o  <= 1'b0;
      held_d <= '0;
      held_b <= 1'b0;
      held_o <= 1'b0;
    end else if (cnt == 0) begin
      if (start) begin
        cnt   <= NSL + 1;
        tmp    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        new_d <= tmp[W-1:0];
        new_b <= ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, bin}));
        sres   = int'($signed(a)) - int'($signed(b)) - int'(bin);
        new_o <= (sres < -(2 ** (W - 1))) || (sres > (2 ** (W - 1)) - 1);
      end
    end else begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        held_d <= new_d;
        held_b <= new_b;
        held_o <= new_o;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, cnt != 0);
    chk("done", done, cnt == 1);
    if (cnt == 1) begin
      chk("diff_done", diff, new_d);
      chk("bout_done", bout, new_b);
`ifdef CSK_SUB_OVF_EN
      chk("ovf_done", ovf, new_o);
`endif
    end else if (cnt == 0) begin
      chk("diff_hold", diff, held_d);
      chk("bout_hold", bout, held_b);
`ifdef CSK_SUB_OVF_EN
      chk("ovf_hold", ovf, held_o);
`endif
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        output logic [W-1:0] rd, output logic rbo);
    int n;
    @(posedge clk); #2;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    rd = '0; rbo = 1'b0; n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done) begin
        rd = diff; rbo = bout;
        break;
      end
    end
    chk("done_latency", n, NSL + 1);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] rd;
    logic         rbo;
    int           ndone;

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op(8'h5A, 8'h23, 1'b0, rd, rbo);
    chk("basic_diff", rd, 8'h37);
    chk("basic_bout", rbo, 0);

    run_op(8'h00, 8'h01, 1'b0, rd, rbo);
    chk("under_diff", rd, 8'hFF);
    chk("under_bout", rbo, 1);

    run_op(8'h55, 8'h55, 1'b1, rd, rbo);
    chk("skip_diff", rd, 8'hFF);
    chk("skip_bout", rbo, 1);

    run_op(8'h80, 8'h01, 1'b0, rd, rbo);
    chk("ovf1_diff", rd, 8'h7F);
    chk("ovf1_bout", rbo, 0);

    run_op(8'h7F, 8'hFF, 1'b0, rd, rbo);
    chk("ovf2_diff", rd, 8'h80);
    chk("ovf2_bout", rbo, 1);

    // start held high: one accept per 4 RUN + DONE + IDLE cycles
    @(posedge clk); #2;
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    ndone = 0; rd = '0; rbo = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        if (ndone == 0) begin
          rd = diff; rbo = bout;
        end
        ndone++;
      end
    end
    start = 1'b0;
    chk("overlap_diff", rd, 8'h0F);
    chk("overlap_bout", rbo, 0);
    chk("overlap_count", ndone, 2);
    repeat (8) @(posedge clk);

    // reset in the second RUN cycle
    @(posedge clk); #2;
    a = 8'hF0; b = 8'h0F; bin = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_diff", diff, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom), rd, rbo);
    end

    // random start traffic with inputs changing every cycle
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #2;
      start = 1'($urandom);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
    start = 1'b0;

    repeat (10) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
